alu_result_stage: RTL

// - Registered output stage directly downstream of the 16-bit combinational ALU.
// - Captures RESULT with its opcode and operands, derives status flags (Z/N/C/V/ILL),
//   and buffers entries in a small FIFO toward the consumer over a valid/ready handshake.
// - Keeps saturating activity counters for debug and performance visibility.

---
 rtl/alu_result_stage_pkg.sv | 26 ++
 rtl/alu_result_stage_if.sv | 31 +++
 rtl/alu_flag_gen.sv | 39 +++
 rtl/alu_result_stage.sv | 82 ++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared ALU opcodes, flag bit indices and FIFO entry type.
// Imported by the flag generator, the interface and the result stage.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHR  = 4'b0110;
  localparam logic [3:0] OP_LAST = 4'b0110;

  localparam int FLG_Z   = 0;
  localparam int FLG_N   = 1;
  localparam int FLG_C   = 2;
  localparam int FLG_V   = 3;
  localparam int FLG_ILL = 4;
  localparam int FLAG_W  = 5;

  typedef struct packed {
    logic [15:0]       result;
    logic [FLAG_W-1:0] flags;
  } entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream (a/b/op/result) and downstream (result/flags) handshakes.
// slave: result stage view; master: producer/consumer view.
interface alu_result_stage_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [15:0]       a;
  logic [15:0]       b;
  logic [3:0]        op;
  logic [15:0]       result_in;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       result_out;
  logic [FLAG_W-1:0] flags_out;

  modport slave (
    input  in_valid, a, b, op, result_in,
    input  out_ready,
    output in_ready, out_valid,
    output result_out, flags_out
  );

  modport master (
    output in_valid, a, b, op, result_in,
    output out_ready,
    input  in_ready, out_valid,
    input  result_out, flags_out
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational status flags {ILL,V,C,N,Z} for one ALU result.
// Ports: a, b, op, r in; flags out.
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [15:0]       a,
  input  logic [15:0]       b,
  input  logic [3:0]        op,
  input  logic [15:0]       r,
  output logic [FLAG_W-1:0] flags
);

  logic c_add;

  assign c_add = (17'(a) + 17'(b)) >= 17'h10000;

  always_comb begin
    flags = '0;
    flags[FLG_Z]   = (r == 16'h0000);
    flags[FLG_N]   = r[15];
    flags[FLG_ILL] = (op > OP_LAST);
    unique case (1'b1)
      (op == OP_ADD): begin
        flags[FLG_C] = c_add;
        flags[FLG_V] = (a[15] == b[15])
                    && (r[15] != a[15]);
      end
      (op == OP_SUB): begin
        flags[FLG_C] = (a < b);
        flags[FLG_V] = (a[15] != b[15])
                    && (r[15] != a[15]);
      end
      (op == OP_SHL): flags[FLG_C] = a[15];
      (op == OP_SHR): flags[FLG_C] = a[0];
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flags at push, DEPTH-entry FIFO, counters.
// Ports: clk, rst_n, io (slave), op_count, ill_count.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_stage_if.slave io,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ill_count
);

  localparam int PW = $clog2(DEPTH);

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PW:0]       cnt;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [FLAG_W-1:0] flags;

  alu_flag_gen u_flags (
    .a     (io.a),
    .b     (io.b),
    .op    (io.op),
    .r     (io.result_in),
    .flags (flags)
  );

  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);
  // Ready depends only on stored state, never on out_ready.
  assign push  = io.in_valid && !full;
  assign pop   = io.out_ready && !empty;

  assign io.in_ready  = !full;
  assign io.out_valid = !empty;

  assign head          = mem[rptr];
  assign io.result_out = empty ? '0 : head.result;
  assign io.flags_out  = empty ? '0 : head.flags;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= '{result: io.result_in,
                     flags:  flags};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count  <= '0;
      ill_count <= '0;
    end else if (push) begin
      if (op_count != '1)
        op_count <= op_count + 1'b1;
      if (flags[FLG_ILL] && ill_count != '1)
        ill_count <= ill_count + 1'b1;
    end
  end

endmodule
